// File: rtl/dram_bridge_pkg.sv
// rtl/dram_bridge_pkg.sv - shared types and constants for the DRAM Avalon bridge
package dram_bridge_pkg;

    localparam int MEM_DATA_BITS = 32;
    localparam int READ_BEATS    = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        RD_WAIT,
        WR_LO,
        WR_HI,
        ACK
    } state_t;

endpackage

// File: rtl/dram_avalon_bridge.sv
// rtl/dram_avalon_bridge.sv - splits 32-bit mem requests into two 16-bit Avalon SDRAM accesses
module dram_avalon_bridge
    import dram_bridge_pkg::*;
#(
    parameter int AV_ADDR_BITS = 22,
    parameter int AV_DATA_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     mem_cs,
    input  logic                     mem_read0_write1,
    input  logic [3:0]               mem_byteenable,
    input  logic [AV_ADDR_BITS-1:0]  mem_addr,
    input  logic [MEM_DATA_BITS-1:0] mem_write_data,
    output logic                     mem_ack,
    output logic [MEM_DATA_BITS-1:0] mem_read_data,
    output logic [AV_ADDR_BITS-1:0]  av_address,
    output logic [1:0]               av_byteenable_n,
    output logic                     av_chipselect,
    output logic                     av_read_n,
    output logic                     av_write_n,
    output logic [AV_DATA_BITS-1:0]  av_writedata,
    input  logic [AV_DATA_BITS-1:0]  av_readdata,
    input  logic                     av_readdatavalid,
    input  logic                     av_waitrequest
);

    state_t                    state_q, state_d;
    logic [1:0]                beat_q, beat_d;
    logic [MEM_DATA_BITS-1:0]  buf_q, buf_d;
    logic [AV_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [3:0]                be_q, be_d;
    logic [MEM_DATA_BITS-1:0]  wdata_q, wdata_d;
    logic                      write_q, write_d;

    logic                      ack_d;
    logic [MEM_DATA_BITS-1:0]  rdata_d;
    logic                      cs_d, read_n_d, write_n_d;
    logic [1:0]                ben_d;
    logic [AV_ADDR_BITS-1:0]   address_d;
    logic [AV_DATA_BITS-1:0]   wrdata_d;
    logic                      retire;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        write_d = write_q;
        ack_d   = 1'b0;
        rdata_d = mem_read_data;
        retire  = !av_waitrequest;

        // Beats outside the read data phase are stray and must not move the counter.
        if (av_readdatavalid && (state_q == RD_HI || state_q == RD_WAIT)) begin
            if (beat_q == 2'd0) begin
                buf_d[AV_DATA_BITS-1:0] = av_readdata;
            end else begin
                buf_d[MEM_DATA_BITS-1:AV_DATA_BITS] = av_readdata;
            end
            beat_d = beat_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (mem_cs) begin
                    addr_d  = mem_addr;
                    be_d    = mem_byteenable;
                    wdata_d = mem_write_data;
                    write_d = mem_read0_write1;
                    beat_d  = 2'd0;
                    if (!mem_read0_write1)             state_d = RD_LO;
                    else if (mem_byteenable[1:0] != 0) state_d = WR_LO;
                    else if (mem_byteenable[3:2] != 0) state_d = WR_HI;
                    else                               state_d = ACK;
                end
            end
            RD_LO:   if (retire) state_d = RD_HI;
            RD_HI:   if (retire) state_d = (beat_d == 2'(READ_BEATS)) ? ACK : RD_WAIT;
            RD_WAIT: if (beat_d == 2'(READ_BEATS)) state_d = ACK;
            WR_LO:   if (retire) state_d = (be_q[3:2] != 0) ? WR_HI : ACK;
            WR_HI:   if (retire) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == ACK && state_q != ACK) begin
            ack_d  = 1'b1;
            beat_d = 2'd0;
            if (!write_d) rdata_d = buf_d;
        end

        // Avalon outputs are registered, so they are derived from the next state.
        cs_d      = 1'b0;
        read_n_d  = 1'b1;
        write_n_d = 1'b1;
        ben_d     = 2'b11;
        address_d = av_address;
        wrdata_d  = av_writedata;
        case (state_d)
            RD_LO: begin
                cs_d      = 1'b1;
                read_n_d  = 1'b0;
                ben_d     = 2'b00;
                address_d = addr_d;
            end
            RD_HI: begin
                cs_d      = 1'b1;
                read_n_d  = 1'b0;
                ben_d     = 2'b00;
                address_d = addr_d + AV_ADDR_BITS'(1);
            end
            WR_LO: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                ben_d     = ~be_d[1:0];
                address_d = addr_d;
                wrdata_d  = wdata_d[AV_DATA_BITS-1:0];
            end
            WR_HI: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                ben_d     = ~be_d[3:2];
                address_d = addr_d + AV_ADDR_BITS'(1);
                wrdata_d  = wdata_d[MEM_DATA_BITS-1:AV_DATA_BITS];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            buf_q           <= '0;
            addr_q          <= '0;
            be_q            <= '0;
            wdata_q         <= '0;
            write_q         <= 1'b0;
            mem_ack         <= 1'b0;
            mem_read_data   <= '0;
            av_chipselect   <= 1'b0;
            av_read_n       <= 1'b1;
            av_write_n      <= 1'b1;
            av_byteenable_n <= 2'b11;
            av_address      <= '0;
            av_writedata    <= '0;
        end else if (sync_reset) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            buf_q           <= '0;
            addr_q          <= '0;
            be_q            <= '0;
            wdata_q         <= '0;
            write_q         <= 1'b0;
            mem_ack         <= 1'b0;
            mem_read_data   <= '0;
            av_chipselect   <= 1'b0;
            av_read_n       <= 1'b1;
            av_write_n      <= 1'b1;
            av_byteenable_n <= 2'b11;
            av_address      <= '0;
            av_writedata    <= '0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            buf_q           <= buf_d;
            addr_q          <= addr_d;
            be_q            <= be_d;
            wdata_q         <= wdata_d;
            write_q         <= write_d;
            mem_ack         <= ack_d;
            mem_read_data   <= rdata_d;
            av_chipselect   <= cs_d;
            av_read_n       <= read_n_d;
            av_write_n      <= write_n_d;
            av_byteenable_n <= ben_d;
            av_address      <= address_d;
            av_writedata    <= wrdata_d;
        end
    end

endmodule

// File: tb/tb_dram_avalon_bridge.sv
// tb/tb_dram_avalon_bridge.sv - directed self-checking bench for dram_avalon_bridge
module tb_dram_avalon_bridge;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sync_reset = 1'b0;
    logic          mem_cs = 1'b0;
    logic          mem_read0_write1 = 1'b0;
    logic [3:0]    mem_byteenable = 4'h0;
    logic [AW-1:0] mem_addr = '0;
    logic [31:0]   mem_write_data = 32'h0;
    logic          mem_ack;
    logic [31:0]   mem_read_data;
    logic [AW-1:0] av_address;
    logic [1:0]    av_byteenable_n;
    logic          av_chipselect, av_read_n, av_write_n;
    logic [15:0]   av_writedata;
    logic [15:0]   av_readdata = 16'h0;
    logic          av_readdatavalid = 1'b0;
    logic          av_waitrequest = 1'b0;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;
    int ack_count = 0;
    int violations = 0;
    bit outstanding = 0;
    int wait_cfg = 0;
    int lat_cfg = 1;
    int wait_left = 0;
    int wn_cycles = 0;
    bit stray_pending = 0;
    logic [15:0] stray_data = 16'h0;

    logic [AW-1:0] log_addr[$];
    logic [15:0]   log_data[$];
    logic [1:0]    log_ben[$];
    logic          log_wr[$];
    logic [15:0]   src[$];
    int            pend_due[$];
    logic [15:0]   pend_data[$];

    dram_avalon_bridge #(.AV_ADDR_BITS(AW), .AV_DATA_BITS(16)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .mem_cs(mem_cs), .mem_read0_write1(mem_read0_write1),
        .mem_byteenable(mem_byteenable), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_ack(mem_ack),
        .mem_read_data(mem_read_data), .av_address(av_address),
        .av_byteenable_n(av_byteenable_n), .av_chipselect(av_chipselect),
        .av_read_n(av_read_n), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_readdatavalid(av_readdatavalid), .av_waitrequest(av_waitrequest)
    );

    always #5 clk = ~clk;

    // Requester-contract monitor: a second mem_cs before mem_ack is a violation.
    always @(posedge clk) begin
        cyc++;
        if (mem_ack) ack_count++;
        if (!reset_n || sync_reset) outstanding = 0;
        else begin
            if (mem_cs) begin
                if (outstanding) violations++;
                else outstanding = 1;
            end
            if (mem_ack) outstanding = 0;
        end
    end

    // Avalon slave model: fixed waitrequest count per command, fixed read latency.
    always @(negedge clk) begin
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            av_readdatavalid = 1'b1;
            av_readdata = pend_data[0];
            void'(pend_due.pop_front());
            void'(pend_data.pop_front());
        end else if (stray_pending) begin
            av_readdatavalid = 1'b1;
            av_readdata = stray_data;
            stray_pending = 0;
        end else begin
            av_readdatavalid = 1'b0;
            av_readdata = 16'h0;
        end
        if (!av_write_n) wn_cycles++;
        if (av_chipselect) begin
            if (wait_left > 0) begin
                av_waitrequest = 1'b1;
                wait_left--;
            end else begin
                av_waitrequest = 1'b0;
                log_addr.push_back(av_address);
                log_data.push_back(av_write_n ? 16'h0 : av_writedata);
                log_ben.push_back(av_byteenable_n);
                log_wr.push_back(!av_write_n);
                if (!av_read_n) begin
                    pend_due.push_back(cyc + lat_cfg);
                    pend_data.push_back(src.size() > 0 ? src.pop_front() : 16'h0);
                end
                wait_left = wait_cfg;
            end
        end else begin
            av_waitrequest = 1'b0;
            wait_left = wait_cfg;
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input int idx, input logic [AW-1:0] a,
                             input logic [15:0] d, input logic [1:0] b, input logic w);
        logic [40:0] got;
        got = '1;
        if (idx < log_addr.size()) got = {log_wr[idx], log_ben[idx], log_data[idx], log_addr[idx]};
        check(tag, 96'(got), 96'({w, b, d, a}));
    endtask

    task automatic check_idle_outs(input string tag);
        check(tag, 96'({mem_ack, mem_read_data, av_address, av_byteenable_n,
                        av_chipselect, av_read_n, av_write_n, av_writedata}),
                   96'({1'b0, 32'h0, 22'h0, 2'b11, 1'b0, 1'b1, 1'b1, 16'h0}));
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_ben.delete();
        log_wr.delete();
    endtask

    // Latency counts negedges from the cycle mem_cs was presented; -1 on timeout.
    task automatic req(input logic wr, input logic [3:0] be, input logic [AW-1:0] a,
                       input logic [31:0] d, output int lat);
        @(negedge clk);
        mem_cs = 1'b1;
        mem_read0_write1 = wr;
        mem_byteenable = be;
        mem_addr = a;
        mem_write_data = d;
        @(negedge clk);
        mem_cs = 1'b0;
        lat = 1;
        while (!mem_ack && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!mem_ack) lat = -1;
        @(negedge clk);
        check("ack_one_cycle", 96'(mem_ack), 96'(1'b0));
    endtask

    initial begin
        int lat;
        int a0;
        int v0;
        int n;

        repeat (2) @(negedge clk);
        check_idle_outs("reset_outs");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full write, zero wait states
        wait_cfg = 0;
        lat_cfg = 1;
        clear_log();
        req(1'b1, 4'hF, 22'h000100, 32'hDEADBEEF, lat);
        check("wr_lat", 96'(lat), 96'(3));
        check("wr_cmds", 96'(log_addr.size()), 96'(2));
        check_cmd("wr_lo", 0, 22'h000100, 16'hBEEF, 2'b00, 1'b1);
        check_cmd("wr_hi", 1, 22'h000101, 16'hDEAD, 2'b00, 1'b1);

        // Read with 3 wait states per command and 4-cycle data latency
        wait_cfg = 3;
        lat_cfg = 4;
        clear_log();
        src.push_back(16'h5678);
        src.push_back(16'h1234);
        a0 = ack_count;
        req(1'b0, 4'hF, 22'h000200, 32'h0, lat);
        check("rd_lat", 96'(lat), 96'(13));
        check("rd_data", 96'(mem_read_data), 96'(32'h12345678));
        check("rd_acks", 96'(ack_count - a0), 96'(1));
        check_cmd("rd_lo", 0, 22'h000200, 16'h0, 2'b00, 1'b0);
        check_cmd("rd_hi", 1, 22'h000201, 16'h0, 2'b00, 1'b0);

        // Partial writes
        wait_cfg = 0;
        lat_cfg = 1;
        clear_log();
        req(1'b1, 4'b1100, 22'h000300, 32'hA1B2C3D4, lat);
        check("be1100_lat", 96'(lat), 96'(2));
        check("be1100_cmds", 96'(log_addr.size()), 96'(1));
        check_cmd("be1100_hi", 0, 22'h000301, 16'hA1B2, 2'b00, 1'b1);
        clear_log();
        req(1'b1, 4'b0010, 22'h000400, 32'h11223344, lat);
        check("be0010_lat", 96'(lat), 96'(2));
        check("be0010_cmds", 96'(log_addr.size()), 96'(1));
        check_cmd("be0010_lo", 0, 22'h000400, 16'h3344, 2'b01, 1'b1);
        clear_log();
        n = wn_cycles;
        req(1'b1, 4'b0000, 22'h000500, 32'h55667788, lat);
        check("be0_lat", 96'(lat), 96'(1));
        check("be0_cmds", 96'(log_addr.size()), 96'(0));
        check("be0_write_n", 96'(wn_cycles - n), 96'(0));
        check("rd_data_hold", 96'(mem_read_data), 96'(32'h12345678));

        // Address wrap: read at top of memory, then odd-address write
        lat_cfg = 2;
        clear_log();
        src.push_back(16'hCAFE);
        src.push_back(16'hBABE);
        req(1'b0, 4'b0000, 22'h3FFFFE, 32'h0, lat);
        check("wrap_rd_data", 96'(mem_read_data), 96'(32'hBABECAFE));
        check_cmd("wrap_rd_lo", 0, 22'h3FFFFE, 16'h0, 2'b00, 1'b0);
        check_cmd("wrap_rd_hi", 1, 22'h3FFFFF, 16'h0, 2'b00, 1'b0);
        clear_log();
        req(1'b1, 4'hF, 22'h3FFFFF, 32'h0BAD0F00, lat);
        check_cmd("wrap_wr_lo", 0, 22'h3FFFFF, 16'h0F00, 2'b00, 1'b1);
        check_cmd("wrap_wr_hi", 1, 22'h000000, 16'h0BAD, 2'b00, 1'b1);

        // Stray readdatavalid in IDLE and during a write must not count
        lat_cfg = 1;
        stray_data = 16'hFFFF;
        stray_pending = 1;
        repeat (3) @(negedge clk);
        wait_cfg = 2;
        stray_pending = 1;
        req(1'b1, 4'hF, 22'h000600, 32'h01020304, lat);
        wait_cfg = 0;
        src.push_back(16'h9ABC);
        src.push_back(16'h5678);
        req(1'b0, 4'hF, 22'h000700, 32'h0, lat);
        check("stray_rd_lat", 96'(lat), 96'(4));
        check("stray_rd_data", 96'(mem_read_data), 96'(32'h56789ABC));

        // Synchronous reset mid-write
        wait_cfg = 3;
        clear_log();
        a0 = ack_count;
        @(negedge clk);
        mem_cs = 1'b1;
        mem_read0_write1 = 1'b1;
        mem_byteenable = 4'hF;
        mem_addr = 22'h000080;
        mem_write_data = 32'h12121212;
        @(negedge clk);
        mem_cs = 1'b0;
        @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        check_idle_outs("sync_reset_outs");
        repeat (6) @(negedge clk);
        check("sync_reset_no_ack", 96'(ack_count - a0), 96'(0));
        check("sync_reset_no_cmd", 96'(log_addr.size()), 96'(0));

        // Asynchronous reset in RD_WAIT after the first beat
        wait_cfg = 3;
        lat_cfg = 4;
        src.push_back(16'hAAAA);
        src.push_back(16'hBBBB);
        a0 = ack_count;
        @(negedge clk);
        mem_cs = 1'b1;
        mem_read0_write1 = 1'b0;
        mem_addr = 22'h000040;
        @(negedge clk);
        mem_cs = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!av_readdatavalid && n < 100);
        check("rst_first_beat_seen", 96'(n < 100), 96'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle_outs("async_reset_outs");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("async_reset_no_ack", 96'(ack_count - a0), 96'(0));
        check("async_reset_rdata", 96'(mem_read_data), 96'(32'h0));
        check("async_reset_stray_gone", 96'(pend_due.size()), 96'(0));
        wait_cfg = 0;
        lat_cfg = 1;
        src.push_back(16'h1111);
        src.push_back(16'h2222);
        req(1'b0, 4'hF, 22'h000044, 32'h0, lat);
        check("post_reset_rd_lat", 96'(lat), 96'(4));
        check("post_reset_rd_data", 96'(mem_read_data), 96'(32'h22221111));

        // mem_cs re-pulsed in WR_HI is ignored and flagged as a contract violation
        wait_cfg = 0;
        clear_log();
        a0 = ack_count;
        v0 = violations;
        @(negedge clk);
        mem_cs = 1'b1;
        mem_read0_write1 = 1'b1;
        mem_byteenable = 4'hF;
        mem_addr = 22'h000010;
        mem_write_data = 32'hCAFEF00D;
        @(negedge clk);
        mem_cs = 1'b0;
        @(negedge clk);
        mem_cs = 1'b1;
        mem_addr = 22'h000020;
        mem_write_data = 32'h99999999;
        @(negedge clk);
        mem_cs = 1'b0;
        repeat (5) @(negedge clk);
        check("repulse_acks", 96'(ack_count - a0), 96'(1));
        check("repulse_cmds", 96'(log_addr.size()), 96'(2));
        check_cmd("repulse_lo", 0, 22'h000010, 16'hF00D, 2'b00, 1'b1);
        check_cmd("repulse_hi", 1, 22'h000011, 16'hCAFE, 2'b00, 1'b1);
        check("repulse_contract", 96'(violations - v0), 96'(1));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
